// File: rtl/fir_pkg.sv
// Shared constants, state type and coefficient table for the time-multiplexed FIR.
package fir_pkg;

   localparam int TAPS   = 51;
   localparam int DATA_W = 12;
   localparam int COEF_W = 16;
   localparam int ACC_W  = 34;
   localparam int SHIFT  = 16;
   localparam int PTR_W  = 6;
   localparam int PROD_W = DATA_W + COEF_W;

   localparam int SAT_MAX = 2047;
   localparam int SAT_MIN = -2048;

   typedef enum logic [1:0] {IDLE, PRIME, MAC, ROUND} state_t;

   // Triangular low-pass kernel, unity DC gain at SHIFT=16 (sum of taps ~ 2^16).
   function automatic logic signed [COEF_W-1:0] coef_at(input int k);
      int d;
      d = (k > TAPS / 2) ? k - TAPS / 2 : TAPS / 2 - k;
      return COEF_W'(96 * (TAPS / 2 + 1 - d));
   endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// Circular sample history: write pointer advances on each stored sample, read
// pointer walks backwards from the newest entry with a registered read port.
module fir_sample_ring
   import fir_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_load,
   input  logic              rd_dec,
   output logic [DATA_W-1:0] rd_data
);

   localparam logic [PTR_W-1:0] LAST = PTR_W'(TAPS - 1);

   logic [DATA_W-1:0] mem [TAPS];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TAPS; i++) mem[i] <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rd_data <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         end
         // rd_load captures the slot being written this cycle, i.e. the newest sample
         if (rd_load)
            rd_ptr <= wr_ptr;
         else if (rd_dec)
            rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - 1'b1;
         rd_data <= mem[rd_ptr];
      end
   end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Single-MAC FIR sequencer: one accepted sample -> PRIME, TAPS MAC cycles, ROUND,
// then a saturated offset-binary result with a one-cycle valid pulse.
module fir_mac_scheduler
   import fir_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   output logic [PTR_W-1:0]  coef_addr,
   input  logic [COEF_W-1:0] coef_data,
   output logic [DATA_W-1:0] filter_out,
   output logic              out_valid,
   output logic              busy,
   output logic              overrun,
   input  logic              clr_overrun
);

   localparam logic [PTR_W-1:0]        LAST  = PTR_W'(TAPS - 1);
   localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(SAT_MAX);
   localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(SAT_MIN);

   state_t                    state;
   logic [PTR_W-1:0]          k;
   logic signed [ACC_W-1:0]   acc;
   logic [DATA_W-1:0]         x;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   y;
   logic [DATA_W-1:0]         y_sat;
   logic                      accept;

   assign accept = sample_valid && (state == IDLE);

   fir_sample_ring u_ring (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (accept),
      .wr_data (sample_in),
      .rd_load (accept),
      .rd_dec  ((state == PRIME) || (state == MAC)),
      .rd_data (x)
   );

   assign prod = $signed(x) * $signed(coef_data);

   always_comb begin
      y     = acc >>> SHIFT;
      y_sat = y[DATA_W-1:0];
      if (y > Y_MAX)
         y_sat = Y_MAX[DATA_W-1:0];
      else if (y < Y_MIN)
         y_sat = Y_MIN[DATA_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         k          <= '0;
         acc        <= '0;
         coef_addr  <= '0;
         filter_out <= 12'h800;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (sample_valid && (state != IDLE))
            overrun <= 1'b1;
         else if (clr_overrun)
            overrun <= 1'b0;

         case (state)
            IDLE: begin
               if (sample_valid) begin
                  k         <= '0;
                  coef_addr <= '0;
                  acc       <= '0;
                  busy      <= 1'b1;
                  state     <= PRIME;
               end
            end
            PRIME: begin
               coef_addr <= PTR_W'(1);
               state     <= MAC;
            end
            MAC: begin
               acc <= acc + ACC_W'(prod);
               // Address runs one tap ahead; park on the last entry rather than leave the table.
               if (coef_addr != LAST)
                  coef_addr <= coef_addr + 1'b1;
               if (k == LAST)
                  state <= ROUND;
               else
                  k <= k + 1'b1;
            end
            ROUND: begin
               filter_out <= {~y_sat[DATA_W-1], y_sat[DATA_W-2:0]};
               out_valid  <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler with a behavioural registered coefficient ROM.
module tb_fir_mac_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] sample_in = '0;
   logic        sample_valid = 1'b0;
   logic        clr_overrun = 1'b0;
   logic [5:0]  coef_addr;
   logic [15:0] coef_data;
   logic [11:0] filter_out;
   logic        out_valid;
   logic        busy;
   logic        overrun;

   int          checks = 0;
   int          errors = 0;
   int          rom_mode = 0;
   logic [15:0] coef_const = 16'd16384;
   int          hist [51];

   fir_mac_scheduler dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .coef_addr    (coef_addr),
      .coef_data    (coef_data),
      .filter_out   (filter_out),
      .out_valid    (out_valid),
      .busy         (busy),
      .overrun      (overrun),
      .clr_overrun  (clr_overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rom_val(input int a);
      if (rom_mode == 1) return 16'((a * 1237) % 8192 - 4096);
      return coef_const;
   endfunction

   always @(posedge clk) coef_data <= rom_val(int'(coef_addr));

   function automatic void model_clear();
      for (int i = 0; i < 51; i++) hist[i] = 0;
   endfunction

   function automatic void model_push(input logic [11:0] s);
      for (int i = 50; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'($signed(s));
   endfunction

   function automatic int model_out();
      longint a;
      longint yv;
      logic [15:0] c;
      a = 0;
      for (int i = 0; i < 51; i++) begin
         c = rom_val(i);
         a += longint'(hist[i]) * longint'($signed(c));
      end
      yv = a >>> 16;
      if (yv > 2047) yv = 2047;
      if (yv < -2048) yv = -2048;
      return int'(yv) + 2048;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one sample at the current negedge and waits for out_valid.
   // n counts negedges from the one following the accepting edge (=1).
   task automatic send(input logic [11:0] d, input int drop_at, input logic [11:0] dv,
                       input int clr_at, output int n);
      sample_in    = d;
      sample_valid = 1'b1;
      n = 0;
      while (n < 70) begin
         @(negedge clk);
         n++;
         sample_valid = (n == drop_at);
         if (n == drop_at) sample_in = dv;
         clr_overrun = (n == clr_at);
         if (out_valid) break;
      end
      sample_valid = 1'b0;
      clr_overrun  = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int n;
      bit seen;

      // Reset state and quiet idle
      repeat (3) @(negedge clk);
      check("rst_filter_out", filter_out, 12'h800);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_coef_addr", coef_addr, 0);
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      check("idle_no_valid", seen, 0);
      check("idle_busy", busy, 0);

      // Impulse through the whole history, then out the far end
      rom_mode = 0; coef_const = 16'd16384;
      for (int i = 0; i < 52; i++) begin
         send((i == 0) ? 12'h400 : 12'h000, 0, 12'h0, 0, n);
         check($sformatf("imp_lat_%0d", i), n, 54);
         check($sformatf("imp_out_%0d", i), filter_out, (i < 51) ? 12'h900 : 12'h800);
      end

      // Saturation both ways
      coef_const = 16'd32767;
      for (int i = 0; i < 51; i++) begin
         send(12'h7FF, 0, 12'h0, 0, n);
         if (i == 0) check("sat_first", filter_out, 12'hBFF);
      end
      check("sat_pos", filter_out, 12'hFFF);
      for (int i = 0; i < 51; i++) send(12'h800, 0, 12'h0, 0, n);
      check("sat_neg", filter_out, 12'h000);

      // Overrun: drop, clear, set-beats-clear
      coef_const = 16'd16384;
      do_reset();
      send(12'h400, 5, 12'h7FF, 0, n);
      check("ovr_lat", n, 54);
      check("ovr_out", filter_out, 12'h900);
      check("ovr_set", overrun, 1);
      send(12'h000, 0, 12'h0, 3, n);
      check("ovr_clr", overrun, 0);
      check("ovr_hist_untouched", filter_out, 12'h900);
      send(12'h000, 4, 12'h123, 4, n);
      check("ovr_set_wins", overrun, 1);
      check("ovr_out2", filter_out, 12'h900);
      clr_overrun = 1'b1;
      @(negedge clk);
      clr_overrun = 1'b0;
      check("ovr_clr2", overrun, 0);

      // Back-to-back samples in the out_valid cycle against the golden model
      do_reset();
      rom_mode = 1;
      model_clear();
      for (int i = 0; i < 100; i++) begin
         logic [11:0] s;
         s = 12'((i * 373 + 91) % 4096);
         model_push(s);
         send(s, 0, 12'h0, 0, n);
         check($sformatf("b2b_lat_%0d", i), n, 54);
         check($sformatf("b2b_out_%0d", i), filter_out, 32'(model_out()));
         check($sformatf("b2b_ovr_%0d", i), overrun, 0);
      end

      // Reset during MAC clears history and suppresses the result
      rom_mode = 0; coef_const = 16'd16384;
      do_reset();
      for (int i = 0; i < 3; i++) send(12'h7FF, 0, 12'h0, 0, n);
      sample_in = 12'h7FF;
      sample_valid = 1'b1;
      for (int i = 1; i <= 22; i++) begin
         @(negedge clk);
         sample_valid = 1'b0;
      end
      check("mid_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_busy_async", busy, 0);
      check("mid_filter_out", filter_out, 12'h800);
      check("mid_coef_addr", coef_addr, 0);
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (i == 3) rst_n = 1'b1;
         if (out_valid) seen = 1;
      end
      check("mid_no_valid", seen, 0);
      send(12'h400, 0, 12'h0, 0, n);
      check("mid_lat", n, 54);
      check("mid_impulse", filter_out, 12'h900);
      check("mid_overrun", overrun, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
